// File: rtl/pkg_neopixel.sv
`default_nettype none
// ============================================================================
//  Package  : pkg_neopixel
//  Brief    : Shared state type, command codes and sizes for the NeoPixel
//             controller SPI command/data decoder.
//  Revision : 1.0  initial release
// ============================================================================
package pkg_neopixel;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONF = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_e;

  localparam logic [7:0] CONF_WR   = 8'h2A;
  localparam logic [7:0] ADDR_WR   = 8'h2B;
  localparam logic [7:0] DATA_WR   = 8'h2C;
  localparam int         CONF_REGS = 6;
  localparam int         CHAN_NUM  = 16;

  function automatic state_e cmd_to_state(input logic [7:0] cmd);
    case (cmd)
      CONF_WR: return CONF;
      ADDR_WR: return ADDR;
      DATA_WR: return DATA;
      default: return IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/channel_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : channel_ctl
//  Brief    : Turns the SPI command/payload byte stream into regfile write
//             strobes and per-channel LED RAM byte-lane write strobes.
//  Revision : 1.0  initial release
// ============================================================================
module channel_ctl
  import pkg_neopixel::*;
(
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                dc_i,
  input  logic                spi_byte_vld_i,
  input  logic [7:0]          spi_byte_data_i,
  input  logic [7:0]          reg_chan_len_i,
  input  logic [3:0]          reg_chan_cnt_i,
  output logic                reg_wr_en_o,
  output logic [2:0]          reg_wr_addr_o,
  output logic [CHAN_NUM-1:0] ram_wr_en_o,
  output logic                ram_wr_done_o,
  output logic [7:0]          ram_wr_addr_o,
  output logic [3:0]          ram_wr_byte_en_o
);

  state_e      state_q;
  logic [2:0]  conf_idx_q;
  logic [3:0]  chan_q;
  logic [7:0]  led_q;
  logic [1:0]  col_q;
  logic        full_q;
  logic        done_q;
  logic        done_d;

  logic w_pay, w_cmd, w_last_led, w_last_chan;
  logic w_conf_wr, w_addr_wr, w_data_wr, w_led_step;

  // Payload is masked by reset so strobes stay low while reset is held.
  assign w_pay       = rst_n_i & spi_byte_vld_i & dc_i;
  assign w_cmd       = spi_byte_vld_i & ~dc_i;
  assign w_last_led  = (led_q == reg_chan_len_i);
  assign w_last_chan = (chan_q == reg_chan_cnt_i);

  assign w_conf_wr  = w_pay && (state_q == CONF) && (conf_idx_q < 3'(CONF_REGS));
  assign w_addr_wr  = w_pay && (state_q == ADDR) && !full_q;
  assign w_data_wr  = w_pay && (state_q == DATA) && !full_q;
  assign w_led_step = w_addr_wr || (w_data_wr && (col_q == 2'd2));
  assign done_d     = w_data_wr && (col_q == 2'd2) && w_last_led && w_last_chan;

  always_comb begin
    ram_wr_byte_en_o = 4'b0000;
    if (w_addr_wr)      ram_wr_byte_en_o = 4'b1000;
    else if (w_data_wr) ram_wr_byte_en_o = 4'b0001 << col_q;
  end

  assign reg_wr_en_o   = w_conf_wr;
  assign reg_wr_addr_o = conf_idx_q;
  assign ram_wr_en_o   = (w_addr_wr || w_data_wr) ? (CHAN_NUM'(1) << chan_q) : '0;
  assign ram_wr_addr_o = led_q;
  assign ram_wr_done_o = done_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      conf_idx_q <= 3'd0;
      chan_q     <= 4'd0;
      led_q      <= 8'd0;
      col_q      <= 2'd0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= done_d;
      if (w_cmd) begin
        state_q    <= cmd_to_state(spi_byte_data_i);
        conf_idx_q <= 3'd0;
        chan_q     <= 4'd0;
        led_q      <= 8'd0;
        col_q      <= 2'd0;
        full_q     <= 1'b0;
      end else begin
        if (w_conf_wr) conf_idx_q <= conf_idx_q + 3'd1;
        if (w_data_wr) col_q <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        // Channel-major walk; the last LED of the last channel freezes the stream.
        if (w_led_step) begin
          if (w_last_led) begin
            led_q <= 8'd0;
            if (w_last_chan) full_q <= 1'b1;
            else             chan_q <= chan_q + 4'd1;
          end else begin
            led_q <= led_q + 8'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_channel_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_channel_ctl
//  Brief    : Self-checking bench for channel_ctl against a stream-index model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_channel_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dc = 1'b0;
  logic        vld = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [7:0]  len = 8'h00;
  logic [3:0]  cnt = 4'h0;
  logic        reg_en;
  logic [2:0]  reg_addr;
  logic [15:0] ram_en;
  logic        done;
  logic [7:0]  ram_addr;
  logic [3:0]  be;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: stream mode (0 idle,1 conf,2 addr,3 data) and payload index since command.
  int   mode = 0;
  int   k = 0;
  logic pend_done = 1'b0;
  logic armed = 1'b0;
  logic [7:0] nlen = 8'h00;
  logic [3:0] ncnt = 4'h0;

  channel_ctl dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .dc_i            (dc),
    .spi_byte_vld_i  (vld),
    .spi_byte_data_i (data),
    .reg_chan_len_i  (len),
    .reg_chan_cnt_i  (cnt),
    .reg_wr_en_o     (reg_en),
    .reg_wr_addr_o   (reg_addr),
    .ram_wr_en_o     (ram_en),
    .ram_wr_done_o   (done),
    .ram_wr_addr_o   (ram_addr),
    .ram_wr_byte_en_o(be)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic [7:0] c);
    if (c == 8'h2A) return 1;
    if (c == 8'h2B) return 2;
    if (c == 8'h2C) return 3;
    return 0;
  endfunction

  // One clock cycle: drive at negedge, check the combinational strobes and the
  // previous cycle's done pulse, then advance the model for the coming edge.
  task automatic step(input logic r, input logic v, input logic d, input logic [7:0] b);
    int nl, tot, ll;
    logic [31:0] e_reg, e_ram, e_be, e_ra, e_la;
    logic nd;
    @(negedge clk);
    rst_n = r; vld = v; dc = d; data = b; len = nlen; cnt = ncnt;
    #1;
    nl  = int'(len) + 1;
    tot = nl * (int'(cnt) + 1);
    e_reg = 0; e_ram = 0; e_be = 0; e_ra = 0; e_la = 0; nd = 1'b0;
    if (r && v && d) begin
      case (mode)
        1: if (k < 6) begin e_reg = 1; e_ra = k; end
        2: if (k < tot) begin e_ram = 32'd1 << (k / nl); e_la = k % nl; e_be = 8; end
        3: if (k < 3 * tot) begin
             ll = k / 3;
             e_ram = 32'd1 << (ll / nl); e_la = ll % nl; e_be = 32'd1 << (k % 3);
             nd = (k == 3 * tot - 1);
           end
        default: ;
      endcase
    end
    if (armed) begin
      chk("done", 32'(done), 32'(pend_done));
      chk("reg_en", 32'(reg_en), e_reg);
      chk("ram_en", 32'(ram_en), e_ram);
      chk("byte_en", 32'(be), e_be);
      if (e_reg != 0) chk("reg_addr", 32'(reg_addr), e_ra);
      if (e_ram != 0) chk("ram_addr", 32'(ram_addr), e_la);
    end
    armed = 1'b1;
    if (!r) begin
      mode = 0; k = 0; pend_done = 1'b0;
    end else begin
      pend_done = nd;
      if (v && !d) begin mode = dec(b); k = 0; end
      else if (v && mode != 0) k++;
    end
  endtask

  task automatic pay(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom));
  endtask

  initial begin
    // Reset held with payload present: nothing may strobe.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom));
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    pay(5);

    // Configuration writes, seventh byte ignored.
    step(1'b1, 1'b1, 1'b0, 8'h2A);
    step(1'b1, 1'b1, 1'b1, 8'h01); step(1'b1, 1'b1, 1'b1, 8'h12);
    step(1'b1, 1'b1, 1'b1, 8'h23); step(1'b1, 1'b1, 1'b1, 8'h34);
    step(1'b1, 1'b1, 1'b1, 8'h3F); step(1'b1, 1'b1, 1'b1, 8'h07);
    pay(2);

    // Full address frame of 8 channels x 64 LEDs plus one excess byte.
    nlen = 8'h3F; ncnt = 4'd7;
    step(1'b1, 1'b1, 1'b0, 8'h2B);
    pay(513);

    // Full colour frame plus one excess byte; done follows the final byte.
    step(1'b1, 1'b1, 1'b0, 8'h2C);
    pay(1537);
    step(1'b1, 1'b0, 1'b1, 8'h00);

    // Restart mid-stream.
    step(1'b1, 1'b1, 1'b0, 8'h2C);
    pay(10);
    step(1'b1, 1'b1, 1'b0, 8'h2C);
    pay(4);

    // Unknown command then payload.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    pay(6);

    // Reset mid-frame: the frame never completes.
    nlen = 8'd1; ncnt = 4'd0;
    step(1'b1, 1'b1, 1'b0, 8'h2C);
    pay(5);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    pay(4);

    // Small randomised frames with gaps, restarts and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      if ($urandom_range(0, 59) == 0) begin
        nlen = 8'($urandom_range(0, 5));
        ncnt = 4'($urandom_range(0, 2));
        sel = $urandom_range(0, 3);
        step(1'b1, 1'b1, 1'b0, (sel == 0) ? 8'h2A : (sel == 1) ? 8'h2B :
                               (sel == 2) ? 8'h2C : 8'($urandom));
      end else if ($urandom_range(0, 299) == 0) begin
        step(1'b0, 1'($urandom), 1'b1, 8'($urandom));
      end else begin
        step(1'b1, ($urandom_range(0, 3) != 0), 1'b1, 8'($urandom));
      end
    end
    step(1'b1, 1'b0, 1'b1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
